// File: rtl/fp_normalizer.sv
// rtl/fp_normalizer.sv - serial normalize-and-round of a 12-bit sign-magnitude word to 1/3/4 float.
// Optional FPN_OVF_FLAG_EN adds the ovf output flagging saturated rounding.
module fp_normalizer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign_in,
  input  logic [11:0] mag_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [2:0]  exp_out,
  output logic [3:0]  sig_out
`ifdef FPN_OVF_FLAG_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [11:0] w_q;
  logic [2:0]  e_q;
  logic        sign_q;
  logic        out_valid_q;
  logic        sign_out_q;
  logic [2:0]  exp_out_q;
  logic [3:0]  sig_out_q;
  logic [4:0]  round_sum_d;
`ifdef FPN_OVF_FLAG_EN
  logic        ovf_q;
`endif

  // Bit 11 is zero for legal inputs; treating it as "already normalized" keeps the shift bounded.
  logic normalized_d;
  assign normalized_d = (w_q[11:10] != 2'b00) || (e_q == 3'd0);
  assign round_sum_d  = {1'b0, w_q[10:7]} + {4'b0000, w_q[6]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      w_q         <= 12'd0;
      e_q         <= 3'd0;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sign_out_q  <= 1'b0;
      exp_out_q   <= 3'd0;
      sig_out_q   <= 4'd0;
`ifdef FPN_OVF_FLAG_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            w_q     <= mag_in;
            e_q     <= 3'd7;
            sign_q  <= sign_in;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (normalized_d) begin
            state_q <= ROUND;
          end else begin
            w_q <= {w_q[10:0], 1'b0};
            e_q <= e_q - 3'd1;
          end
        end
        ROUND: begin
          sign_out_q  <= sign_q;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
          if (!round_sum_d[4]) begin
            sig_out_q <= round_sum_d[3:0];
            exp_out_q <= e_q;
`ifdef FPN_OVF_FLAG_EN
            ovf_q     <= 1'b0;
`endif
          end else if (e_q != 3'd7) begin
            // Carry out of the significand renormalizes to 1.000 at the next exponent.
            sig_out_q <= 4'b1000;
            exp_out_q <= e_q + 3'd1;
`ifdef FPN_OVF_FLAG_EN
            ovf_q     <= 1'b0;
`endif
          end else begin
            sig_out_q <= 4'b1111;
            exp_out_q <= 3'd7;
`ifdef FPN_OVF_FLAG_EN
            ovf_q     <= 1'b1;
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign sign_out  = sign_out_q;
  assign exp_out   = exp_out_q;
  assign sig_out   = sig_out_q;
`ifdef FPN_OVF_FLAG_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_fp_normalizer.sv
// tb/tb_fp_normalizer.sv - scoreboard bench for fp_normalizer with a behavioural float model.
module tb_fp_normalizer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign_in = 1'b0;
  logic [11:0] mag_in = 12'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        sign_out;
  logic [2:0]  exp_out;
  logic [3:0]  sig_out;
`ifdef FPN_OVF_FLAG_EN
  logic        ovf;
`endif

  fp_normalizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .mag_in    (mag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sign_out  (sign_out),
    .exp_out   (exp_out),
    .sig_out   (sig_out)
`ifdef FPN_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       s;
    logic [2:0] e;
    logic [3:0] g;
    logic       o;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;
  bit   in_reset = 1'b1;
  bit   bp_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Value-level model: locate the leading one, scale it toward bit 10 (at most 7 steps),
  // then round half-up on the bit below the 4-bit significand.
  function automatic exp_t model(input logic s, input int mag);
    exp_t x;
    int msb = -1;
    int k, m, top, rbit, sum, ee;
    for (int i = 0; i <= 10; i++) if ((mag >> i) & 1) msb = i;
    k = (msb < 0) ? 7 : ((10 - msb) > 7 ? 7 : 10 - msb);
    m = mag * (1 << k);
    top = (m / 128) % 16;
    rbit = (m / 64) % 2;
    sum = top + rbit;
    ee = 7 - k;
    x.s = s;
    x.o = 1'b0;
    x.lat = k + 2;
    x.acc = 0;
    if (sum < 16) begin
      x.e = 3'(ee);
      x.g = 4'(sum);
    end else if (ee < 7) begin
      x.e = 3'(ee + 1);
      x.g = 4'd8;
    end else begin
      x.e = 3'd7;
      x.g = 4'd15;
      x.o = 1'b1;
    end
    return x;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic send(input logic s, input logic [11:0] m);
    exp_t x;
    int t = 0;
    x = model(s, int'(m));
    sign_in  = s;
    mag_in   = m;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 100) chk("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
    x.acc = cyc;
    sbq.push_back(x);
    in_valid = 1'b0;
    sign_in  = 1'($urandom);
    mag_in   = 12'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while ((sbq.size() != 0 || out_valid) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 300) chk("drain_timeout", 32'(t), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!bp_mode) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on each new result, checks latency, values, stability and handshake release.
  initial begin
    exp_t cur;
    bit   seen = 1'b0;
    bit   hs = 1'b0;
    forever begin
      @(negedge clk);
      if (in_reset) begin
        seen = 1'b0;
        hs = 1'b0;
      end else if (hs) begin
        chk("hs_out_valid_fall", 32'(out_valid), 32'd0);
        chk("hs_in_ready_rise", 32'(in_ready), 32'd1);
        hs = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          if (sbq.size() == 0) begin
            chk("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            cur = sbq.pop_front();
            chk("latency", 32'(cyc - cur.acc), 32'(cur.lat));
          end
          seen = 1'b1;
        end
        chk("sign_out", 32'(sign_out), 32'(cur.s));
        chk("exp_out", 32'(exp_out), 32'(cur.e));
        chk("sig_out", 32'(sig_out), 32'(cur.g));
`ifdef FPN_OVF_FLAG_EN
        chk("ovf", 32'(ovf), 32'(cur.o));
`endif
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        if (out_ready) begin
          hs = 1'b1;
          seen = 1'b0;
        end
      end
    end
  end

  initial begin
    int t;
    logic [11:0] m;
    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_outputs", 32'({sign_out, exp_out, sig_out}), 32'd0);
`ifdef FPN_OVF_FLAG_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed corners
    send(1'b0, 12'h7FF);
    send(1'b0, 12'h07D);
    send(1'b0, 12'h01A);
    send(1'b1, 12'h005);
    send(1'b0, 12'h000);
    send(1'b1, 12'h000);
    send(1'b1, 12'h400);
    send(1'b0, 12'h3FF);
    send(1'b0, 12'h040);
    drain();

    // Backpressure: hold out_ready low five cycles after out_valid rises
    bp_mode = 1'b1;
    out_ready = 1'b0;
    send(1'b0, 12'h07D);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 50) chk("bp_valid_timeout", 32'(t), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bp_mode = 1'b0;
    drain();

    // Randomized magnitudes spread across all shift counts
    for (int i = 0; i < 60; i++) begin
      m = 12'(($urandom % 2048) >> $urandom_range(0, 11));
      send(1'($urandom), m);
    end
    drain();

    // Asynchronous reset mid-SHIFT after a nonzero result is parked on the outputs
    send(1'b1, 12'h7FF);
    drain();
    send(1'b0, 12'h003);
    repeat (3) @(posedge clk);
    #3;
    in_reset = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_outputs", 32'({sign_out, exp_out, sig_out}), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef FPN_OVF_FLAG_EN
    chk("async_rst_ovf", 32'(ovf), 32'd0);
`endif
    if (sbq.size() != 0) void'(sbq.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_reset = 1'b0;
    @(posedge clk);
    #1;
    send(1'b0, 12'h01A);
    send(1'b1, 12'h005);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
